// File: rtl/mult_req_sched_if.sv
// Requester/response channel bundle for mult_req_sched: per-requester valid/ready
// with packed 4-bit operands, plus the single valid/ready response channel.
interface mult_req_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_prod;
    logic              rsp_err;

    // master: the requester fabric; slave: the scheduler
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err
    );
endinterface

// File: rtl/mult_req_sched.sv
// Round-robin scheduler sharing one START/READY 4x4 multiplier among NREQ requesters.
// Optional WAIT-state timeout completion is enabled by defining MULT_SCHED_TIMEOUT_EN.
module mult_req_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MIN_LAT = 2,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    mult_req_sched_if.slave bus,
    output logic            mul_start,
    output logic [3:0]      mul_a,
    output logic [3:0]      mul_b,
    input  logic            mul_ready,
    input  logic [7:0]      mul_p,
    output logic            busy
);
    localparam int CMAX = (MIN_LAT > TIMEOUT) ? MIN_LAT : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 2);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  cnt;
    logic [3:0]     op_a;
    logic [3:0]     op_b;
    logic [IDW-1:0] op_id;
    logic [7:0]     prod_q;

    logic           gnt_found;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] cand;

    // Search starts at rr_ptr and wraps naturally because NREQ == 2**IDW.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = rr_ptr + IDW'(k);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == S_IDLE && gnt_found) bus.req_ready[gnt_id] = 1'b1;
    end

`ifdef MULT_SCHED_TIMEOUT_EN
    logic err_q;
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
        if (reset) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_id  <= '0;
            prod_q <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (gnt_found) begin
                    op_a  <= bus.req_a[{gnt_id, 2'b00} +: 4];
                    op_b  <= bus.req_b[{gnt_id, 2'b00} +: 4];
                    op_id <= gnt_id;
                    state <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    // READY before MIN_LAT may be left over from the previous operation.
                    if (cnt >= CW'(MIN_LAT) && mul_ready) begin
                        prod_q <= mul_p;
`ifdef MULT_SCHED_TIMEOUT_EN
                        err_q  <= 1'b0;
`endif
                        state  <= S_RESP;
                    end
`ifdef MULT_SCHED_TIMEOUT_EN
                    else if (cnt >= CW'(TIMEOUT)) begin
                        prod_q <= '0;
                        err_q  <= 1'b1;
                        state  <= S_RESP;
                    end
`endif
                end
                S_RESP: if (bus.rsp_ready) begin
                    rr_ptr <= op_id + IDW'(1);
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mul_start     = (state == S_LAUNCH);
    assign busy          = (state != S_IDLE);
    assign mul_a         = (state == S_IDLE) ? 4'd0 : op_a;
    assign mul_b         = (state == S_IDLE) ? 4'd0 : op_b;
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_id    = op_id;
    assign bus.rsp_prod  = prod_q;
endmodule

// File: tb/tb_mult_req_sched.sv
// Randomised and directed bench for mult_req_sched against a timestamp-based
// transaction model; a behavioural multiplier with configurable READY latency drives mul_*.
module tb_mult_req_sched;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int MIN_LAT = 2;
    localparam int TIMEOUT = 16;
    localparam int AW      = 4 * NREQ;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mult_req_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    logic       mul_start;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic       mul_ready;
    logic [7:0] mul_p;
    logic       busy;

    mult_req_sched #(.NREQ(NREQ), .IDW(IDW), .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ready(mul_ready), .mul_p(mul_p), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier: mode 0 raises READY lat cycles after START and holds it until the
    // next START; mode 1 holds READY high; mode 2 never raises READY.
    int         mmode = 0;
    int         lat = 3;
    int         mcnt = 0;
    logic       nxt_rdy = 1'b0;
    logic       rdy0 = 1'b0;
    logic [7:0] lat_p = 8'd0;

    always @(negedge clk) begin
        if (reset) begin
            mcnt    = 0;
            nxt_rdy = 1'b0;
        end else if (mul_start) begin
            lat_p   = 8'({4'd0, mul_a} * {4'd0, mul_b});
            mcnt    = lat - 1;
            nxt_rdy = (mcnt == 0);
        end else begin
            if (mcnt > 0) mcnt--;
            nxt_rdy = (mcnt == 0);
        end
    end
    always @(posedge clk) begin
        #1;
        rdy0 = nxt_rdy;
    end
    assign mul_ready = (mmode == 0) ? rdy0 : (mmode == 1);
    assign mul_p     = (mmode == 1) ? 8'({4'd0, mul_a} * {4'd0, mul_b}) : lat_p;

    // Transaction model: one operation at a time, described by its handshake
    // cycle and the cycle its response becomes due.
    bit             m_busy = 1'b0;
    int             m_rr = 0;
    int             m_id, m_a, m_b, t_hs, t_rsp, m_prod, m_err;
    bit             m_done;
    int             g, d, w;
    bit             found, rv;
    logic [NREQ-1:0] exp_rdy;

    always @(negedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
            m_rr   = 0;
        end else if (!m_busy) begin
            found   = 1'b0;
            g       = 0;
            exp_rdy = '0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && bus.req_valid[(m_rr + k) % NREQ]) begin
                    found = 1'b1;
                    g     = (m_rr + k) % NREQ;
                end
            end
            if (found) exp_rdy[g] = 1'b1;
            check("idle_req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            check("idle_busy", 32'(busy), 0);
            check("idle_mul_start", 32'(mul_start), 0);
            check("idle_rsp_valid", 32'(bus.rsp_valid), 0);
            check("idle_mul_ab", 32'({mul_a, mul_b}), 0);
            if (found) begin
                m_busy = 1'b1;
                m_id   = g;
                m_a    = 32'(bus.req_a[4*g +: 4]);
                m_b    = 32'(bus.req_b[4*g +: 4]);
                t_hs   = cyc;
                m_done = 1'b0;
            end
        end else begin
            d = cyc - t_hs;
            check("op_req_ready", 32'(bus.req_ready), 0);
            check("op_busy", 32'(busy), 1);
            check("op_mul_start", 32'(mul_start), 32'(d == 1));
            check("op_mul_a", 32'(mul_a), 32'(m_a));
            check("op_mul_b", 32'(mul_b), 32'(m_b));
            if (!m_done && d >= 2) begin
                w = d - 2;
                if (w >= MIN_LAT && mul_ready) begin
                    m_done = 1'b1; t_rsp = cyc + 1; m_prod = m_a * m_b; m_err = 0;
                end
`ifdef MULT_SCHED_TIMEOUT_EN
                else if (w >= TIMEOUT) begin
                    m_done = 1'b1; t_rsp = cyc + 1; m_prod = 0; m_err = 1;
                end
`endif
            end
            rv = m_done && (cyc >= t_rsp);
            check("op_rsp_valid", 32'(bus.rsp_valid), 32'(rv));
            if (rv) begin
                check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
                check("rsp_prod", 32'(bus.rsp_prod), 32'(m_prod));
                check("rsp_err", 32'(bus.rsp_err), 32'(m_err));
                if (bus.rsp_ready) begin
                    m_rr   = (m_id + 1) % NREQ;
                    m_busy = 1'b0;
                end
            end
        end
    end

    // Observer used by the directed tests.
    logic [NREQ-1:0] hs_mask = '0;
    int              starts = 0;
    logic [3:0]      st_a, st_b;
    logic [IDW-1:0]  acc_id[$];
    logic [7:0]      acc_prod[$];

    always @(negedge clk) begin
        if (!reset) begin
            hs_mask = hs_mask | (bus.req_valid & bus.req_ready);
            if (mul_start) begin
                starts++;
                st_a = mul_a;
                st_b = mul_b;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                acc_id.push_back(bus.rsp_id);
                acc_prod.push_back(bus.rsp_prod);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset         = 1'b1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_mul_start"}, 32'(mul_start), 0);
        check({tag, "_mul_ab"}, 32'({mul_a, mul_b}), 0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rsp_fields"}, 32'({bus.rsp_id, bus.rsp_prod, bus.rsp_err}), 0);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    endtask

    // Presents one request for a single cycle; the scheduler must be idle.
    task automatic drive_req(input int id, input int a, input int b, output int hs);
        @(posedge clk); #1;
        bus.req_valid = NREQ'(1 << id);
        bus.req_a     = AW'(a << (4 * id));
        bus.req_b     = AW'(b << (4 * id));
        hs            = cyc;
        @(posedge clk); #1;
        bus.req_valid = '0;
    endtask

    task automatic wait_rsp(input int maxc, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({nm, "_rsp_timeout"}, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int hs;
    int guard;
    logic [7:0] exp_p[4];

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        do_reset();
        chk_zero("reset");

        // Single request from requester 0, READY five cycles after START.
        mmode = 0; lat = 5; starts = 0; bus.rsp_ready = 1'b1;
        drive_req(0, 3, 5, hs);
        wait_rsp(30, "t1");
        check("t1_latency", 32'(cyc - hs), 7);
        check("t1_prod", 32'(bus.rsp_prod), 15);
        check("t1_id", 32'(bus.rsp_id), 0);
        check("t1_err", 32'(bus.rsp_err), 0);
        check("t1_starts", 32'(starts), 1);
        check("t1_mul_ab", 32'({st_a, st_b}), 32'({4'd3, 4'd5}));

        // All four requesters valid together.
        do_reset();
        acc_id.delete(); acc_prod.delete(); hs_mask = '0; lat = 2;
        @(posedge clk); #1;
        bus.req_a     = {4'd15, 4'd5, 4'd3, 4'd1};
        bus.req_b     = {4'd15, 4'd6, 4'd4, 4'd2};
        bus.req_valid = '1;
        guard = 0;
        while (acc_id.size() < 4 && guard < 200) begin
            @(posedge clk); #1;
            bus.req_valid = ~hs_mask;
            guard++;
        end
        bus.req_valid = '0;
        exp_p = '{8'h02, 8'h0C, 8'h1E, 8'hE1};
        check("t2_count", 32'(acc_id.size()), 4);
        if (acc_id.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_order", 32'(acc_id[i]), 32'(i));
                check("t2_prod", 32'(acc_prod[i]), 32'(exp_p[i]));
            end
        end

        // Response stalled for five cycles while every requester asks.
        bus.rsp_ready = 1'b0; lat = 3;
        drive_req(3, 7, 9, hs);
        wait_rsp(30, "t3");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.req_valid = '1;
            @(negedge clk);
            check("t3_hold_valid", 32'(bus.rsp_valid), 1);
            check("t3_hold_id", 32'(bus.rsp_id), 3);
            check("t3_hold_prod", 32'(bus.rsp_prod), 63);
            check("t3_req_ready", 32'(bus.req_ready), 0);
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("t3_busy_accept", 32'(busy), 1);
        @(negedge clk);
        check("t3_busy_after", 32'(busy), 0);

        // READY held high: capture exactly when the counter reaches MIN_LAT.
        mmode = 1;
        drive_req(1, 0, 9, hs);
        wait_rsp(30, "t4a");
        check("t4a_latency", 32'(cyc - hs), 32'(3 + MIN_LAT));
        check("t4a_prod", 32'(bus.rsp_prod), 0);
        check("t4a_id", 32'(bus.rsp_id), 1);
        drive_req(2, 6, 7, hs);
        wait_rsp(30, "t4b");
        check("t4b_latency", 32'(cyc - hs), 32'(3 + MIN_LAT));
        check("t4b_prod", 32'(bus.rsp_prod), 42);

        // READY stuck low.
        mmode = 2;
        drive_req(0, 2, 2, hs);
`ifdef MULT_SCHED_TIMEOUT_EN
        wait_rsp(TIMEOUT + 20, "t5");
        check("t5_latency", 32'(cyc - hs), 32'(TIMEOUT + 3));
        check("t5_err", 32'(bus.rsp_err), 1);
        check("t5_prod", 32'(bus.rsp_prod), 0);
`else
        repeat (40) @(negedge clk);
        check("t5_busy", 32'(busy), 1);
        check("t5_no_rsp", 32'(bus.rsp_valid), 0);
`endif
        mmode = 0;
        do_reset();

        // Reset during WAIT after the pointer has advanced to 3.
        lat = 2;
        drive_req(2, 4, 4, hs);
        wait_rsp(30, "t6a");
        mmode = 2;
        drive_req(3, 5, 5, hs);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mmode = 0;
        chk_zero("t6_after_reset");
        hs_mask = '0;
        @(posedge clk); #1;
        bus.req_a     = {4'd1, 4'd3, 4'd0, 4'd0};
        bus.req_b     = {4'd1, 4'd4, 4'd0, 4'd0};
        bus.req_valid = 4'b1100;
        @(posedge clk); #1;
        bus.req_valid = '0;
        check("t6_grant", 32'(hs_mask), 32'(4'b0100));
        wait_rsp(30, "t6b");
        check("t6_id", 32'(bus.rsp_id), 2);
        check("t6_prod", 32'(bus.rsp_prod), 12);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (c % 250 == 0) mmode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            bus.req_valid = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
            bus.req_a     = AW'($urandom);
            bus.req_b     = AW'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            lat           = $urandom_range(1, 6);
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("final_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
